// File: rtl/cpu_pkg.sv
// Shared encodings for the single-cycle RV32I integer core: opcodes, funct fields
// and the ALU operation set used between the decoder and the ALU.
package cpu_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    // Operation selected by funct3 alone; SUB and SRA are layered on by the decoder.
    function automatic alu_op_e baseOp(input logic [2:0] funct3);
        case (funct3)
            F3_ADD:  return ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Purely combinational 32-bit integer ALU; shifts use only the low five bits of b.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     alu_op,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// Single-cycle RV32I integer-ALU core: decodes R/I-type ALU instructions, reads the
// register file, and writes the result plus a zero flag on each rising edge.
module cpu
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in,
    output logic        zero
);

    logic [31:0] regFile_q [32];
    logic        zero_q;
    logic        zero_d;

    logic [6:0]  opcode;
    logic [4:0]  rdIdx;
    logic [2:0]  funct3;
    logic [4:0]  rs1Idx;
    logic [4:0]  rs2Idx;
    logic [6:0]  funct7;
    logic [31:0] immVal;
    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
    logic [31:0] opB;
    logic [31:0] aluResult;
    alu_op_e     aluOp;
    logic        execValid;

    assign opcode = in[6:0];
    assign rdIdx  = in[11:7];
    assign funct3 = in[14:12];
    assign rs1Idx = in[19:15];
    assign rs2Idx = in[24:20];
    assign funct7 = in[31:25];
    assign immVal = {{20{in[31]}}, in[31:20]};

    assign rs1Val = (rs1Idx == 5'd0) ? 32'd0 : regFile_q[rs1Idx];
    assign rs2Val = (rs2Idx == 5'd0) ? 32'd0 : regFile_q[rs2Idx];

    // Unknown opcodes and unsupported R-type funct7 values leave execValid low,
    // which suppresses both the register write and the zero-flag update.
    always_comb begin
        aluOp     = baseOp(funct3);
        opB       = rs2Val;
        execValid = 1'b0;
        case (opcode)
            OP_R: begin
                execValid = 1'b1;
                if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    aluOp = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    aluOp = ALU_SRA;
                end else if (funct7 != F7_BASE) begin
                    execValid = 1'b0;
                end
            end
            OP_I: begin
                execValid = 1'b1;
                opB       = immVal;
                if (funct3 == F3_SR && in[30]) begin
                    aluOp = ALU_SRA;
                end
            end
            default: execValid = 1'b0;
        endcase
    end

    cpu_alu u_alu (
        .a      (rs1Val),
        .b      (opB),
        .alu_op (aluOp),
        .result (aluResult)
    );

    assign zero_d = execValid ? (aluResult == 32'd0) : zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regFile_q[i] <= '0;
            end
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
            if (execValid && rdIdx != 5'd0) begin
                regFile_q[rdIdx] <= aluResult;
            end
        end
    end

    assign zero = zero_q;

endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for cpu: walks a hand-computed instruction sequence
// and checks register contents and the zero flag after every edge.
module tb_cpu;

    logic        clk;
    logic        rst;
    logic [31:0] in;
    logic        zero;

    int compared   = 0;
    int mismatched = 0;

    cpu dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] iType(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    // Presents one instruction before the edge and returns 1 time unit after it.
    task automatic applyStimulus(input logic [31:0] instr, input logic rstVal);
        @(negedge clk);
        in  = instr;
        rst = rstVal;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        in  = '0;
        rst = 1'b1;

        applyStimulus(rType(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1'b1);
        applyStimulus(rType(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1'b1);
        checkOutput("reset zero", {31'b0, zero}, 32'd0);
        checkOutput("reset x3", dut.regFile_q[3], 32'd0);

        applyStimulus(32'b0000000_00010_00001_000_00011_0110011, 1'b0);
        checkOutput("add x3", dut.regFile_q[3], 32'd0);
        checkOutput("add x3 zero", {31'b0, zero}, 32'd1);

        applyStimulus(32'b000001100011_00100_000_10000_0010011, 1'b0);
        checkOutput("addi x16", dut.regFile_q[16], 32'd99);
        checkOutput("addi x16 zero", {31'b0, zero}, 32'd0);

        applyStimulus(32'b0000000_10000_10000_000_00111_0110011, 1'b0);
        checkOutput("add x7", dut.regFile_q[7], 32'd198);
        checkOutput("add x7 zero", {31'b0, zero}, 32'd0);

        applyStimulus(iType(12'hFFF, 5'd0, 3'b000, 5'd5, 7'b0010011), 1'b0);
        checkOutput("addi x5 -1", dut.regFile_q[5], 32'hFFFF_FFFF);

        applyStimulus(rType(7'h20, 5'd5, 5'd5, 3'b000, 5'd6), 1'b0);
        checkOutput("sub x6", dut.regFile_q[6], 32'd0);
        checkOutput("sub x6 zero", {31'b0, zero}, 32'd1);

        applyStimulus(iType(12'h404, 5'd5, 3'b101, 5'd8, 7'b0010011), 1'b0);
        checkOutput("srai x8", dut.regFile_q[8], 32'hFFFF_FFFF);

        applyStimulus(iType(12'd28, 5'd5, 3'b101, 5'd9, 7'b0010011), 1'b0);
        checkOutput("srli x9", dut.regFile_q[9], 32'h0000_000F);

        applyStimulus(iType(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011), 1'b0);
        checkOutput("x0 write ignored", dut.rs1Val, 32'd0);
        checkOutput("addi x0 zero", {31'b0, zero}, 32'd0);

        applyStimulus(rType(7'h00, 5'd0, 5'd5, 3'b010, 5'd10), 1'b0);
        checkOutput("slt x10", dut.regFile_q[10], 32'd1);

        applyStimulus(rType(7'h00, 5'd0, 5'd5, 3'b011, 5'd11), 1'b0);
        checkOutput("sltu x11", dut.regFile_q[11], 32'd0);
        checkOutput("sltu x11 zero", {31'b0, zero}, 32'd1);

        applyStimulus(rType(7'h01, 5'd16, 5'd16, 3'b000, 5'd20), 1'b0);
        checkOutput("bad funct7 x20", dut.regFile_q[20], 32'd0);
        checkOutput("bad funct7 zero held", {31'b0, zero}, 32'd1);

        applyStimulus(iType(12'd1, 5'd16, 3'b000, 5'd16, 7'b0010011), 1'b0);
        checkOutput("addi x16 self", dut.regFile_q[16], 32'd100);

        applyStimulus(rType(7'h00, 5'd7, 5'd16, 3'b100, 5'd12), 1'b0);
        checkOutput("xor x12", dut.regFile_q[12], 32'd162);

        applyStimulus(rType(7'h00, 5'd9, 5'd16, 3'b001, 5'd13), 1'b0);
        checkOutput("sll x13", dut.regFile_q[13], 32'd3276800);

        applyStimulus(iType(12'd0, 5'd5, 3'b010, 5'd14, 7'b0010011), 1'b0);
        checkOutput("slti x14", dut.regFile_q[14], 32'd1);

        applyStimulus(iType(12'hFFF, 5'd16, 3'b011, 5'd15, 7'b0010011), 1'b0);
        checkOutput("sltiu x15", dut.regFile_q[15], 32'd1);

        applyStimulus(iType(12'h0F0, 5'd5, 3'b111, 5'd17, 7'b0010011), 1'b0);
        checkOutput("andi x17", dut.regFile_q[17], 32'h0000_00F0);

        applyStimulus(iType(12'hFF0, 5'd0, 3'b110, 5'd18, 7'b0010011), 1'b0);
        checkOutput("ori x18", dut.regFile_q[18], 32'hFFFF_FFF0);

        applyStimulus(rType(7'h20, 5'd9, 5'd18, 3'b101, 5'd19), 1'b0);
        checkOutput("sra x19", dut.regFile_q[19], 32'hFFFF_FFFF);

        applyStimulus(rType(7'h00, 5'd5, 5'd5, 3'b000, 5'd21), 1'b0);
        checkOutput("add wrap x21", dut.regFile_q[21], 32'hFFFF_FFFE);

        applyStimulus(iType(12'd33, 5'd0, 3'b000, 5'd24, 7'b0010011), 1'b0);
        applyStimulus(rType(7'h00, 5'd24, 5'd16, 3'b001, 5'd23), 1'b0);
        checkOutput("sll low5 x23", dut.regFile_q[23], 32'd200);

        applyStimulus(iType(12'd1, 5'd5, 3'b000, 5'd22, 7'b0010011), 1'b0);
        checkOutput("addi wrap x22", dut.regFile_q[22], 32'd0);
        checkOutput("addi wrap zero", {31'b0, zero}, 32'd1);

        applyStimulus(iType(12'd9, 5'd0, 3'b000, 5'd25, 7'b0010011), 1'b1);
        checkOutput("mid reset zero", {31'b0, zero}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("mid reset x%0d", i), dut.regFile_q[i], 32'd0);
        end

        applyStimulus(iType(12'd7, 5'd0, 3'b000, 5'd1, 7'b0010011), 1'b0);
        checkOutput("post reset x1", dut.regFile_q[1], 32'd7);
        applyStimulus(iType(12'd0, 5'd0, 3'b000, 5'd2, 7'b0010011), 1'b0);
        checkOutput("post reset zero", {31'b0, zero}, 32'd1);

        applyStimulus(iType(12'd4, 5'd0, 3'b010, 5'd1, 7'b0000011), 1'b0);
        checkOutput("bad opcode x1", dut.regFile_q[1], 32'd7);
        checkOutput("bad opcode zero held", {31'b0, zero}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
